// File: rtl/rgb_pkg.sv
// Shared constants and helpers for the RGB colour sequencer.
package rgb_pkg;

  // Widest colour word and channel field that chan_slice can handle.
  localparam int unsigned MAX_COLOR_W = 256;
  localparam int unsigned MAX_BITS    = 32;

  // Default rainbow palette, 8-bit RRGGBB words.
  localparam int unsigned RAINBOW_N = 7;
  localparam logic [23:0] RAINBOW [RAINBOW_N] = '{
    24'h9400D3, 24'h4B0082, 24'h0000FF, 24'h00FF00,
    24'hFFFF00, 24'hFF7F00, 24'hFA1010
  };

  // Palette index movement chosen for the current cycle.
  typedef enum logic [1:0] {
    MOVE_NONE = 2'd0,
    MOVE_FWD  = 2'd1,
    MOVE_BACK = 2'd2
  } move_e;

  // Extract channel 'chan' (field width 'bits', channel 0 = LSB field)
  // from a zero-extended colour word.
  function automatic logic [MAX_BITS-1:0] chan_slice(
    input logic [MAX_COLOR_W-1:0] color,
    input int unsigned            bits,
    input int unsigned            chan
  );
    logic [MAX_COLOR_W-1:0] shifted;
    logic [MAX_BITS-1:0]    mask;
    shifted = color >> (chan * bits);
    mask    = (MAX_BITS'(1) << bits) - MAX_BITS'(1);
    return shifted[MAX_BITS-1:0] & mask;
  endfunction

endpackage

// File: rtl/rgb_pwm_channel.sv
// One PWM output: shadow duty latched at the period boundary, compare
// against the shared counter, optional inversion, registered pin.
module rgb_pwm_channel #(
  parameter int unsigned BITS   = 8,
  parameter int unsigned INVERT = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [BITS-1:0] pwm_cnt_i,
  input  logic            period_start_i,
  input  logic [BITS-1:0] duty_i,
  output logic            pin_o
);

  localparam logic INV = (INVERT != 0);

  logic [BITS-1:0] shadow_q;
  logic            pin_q;

  // Shadow duty only changes as the counter wraps to 0, so every period
  // uses a single duty value; the pin is registered off the compare.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow_q <= '0;
      pin_q    <= INV;
    end else begin
      if (period_start_i) begin
        shadow_q <= duty_i;
      end
      pin_q <= (pwm_cnt_i < shadow_q) ^ INV;
    end
  end

  assign pin_o = pin_q;

endmodule

// File: rtl/rgb_sequencer.sv
// Colour sequencer: writable palette, dwell timer with manual stepping,
// optional per-channel crossfade, and CHANNELS PWM outputs.
module rgb_sequencer
  import rgb_pkg::*;
#(
  parameter int unsigned CHANNELS      = 3,
  parameter int unsigned BITS          = 8,
  parameter int unsigned STEPS         = 7,
  parameter int unsigned STEP_CYCLES   = 25000000,
  parameter int unsigned PRESCALE_LOG2 = 7,
  parameter int unsigned FADE_LOG2     = 10,
  parameter int unsigned INVERT        = 1
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       run,
  input  logic                       step_next,
  input  logic                       step_prev,
  input  logic                       fade_en,
  input  logic                       wr_en,
  input  logic [$clog2(STEPS)-1:0]   wr_addr,
  input  logic [CHANNELS*BITS-1:0]   wr_data,
  output logic [$clog2(STEPS)-1:0]   cur_index,
  output logic [CHANNELS*BITS-1:0]   cur_color,
  output logic                       wrap,
  output logic [CHANNELS-1:0]        PWM_PIN
);

  localparam int unsigned IW  = $clog2(STEPS);
  localparam int unsigned IW1 = IW + 1;
  localparam int unsigned CW  = CHANNELS * BITS;
  localparam int unsigned DW  = $clog2(STEP_CYCLES);
  localparam int unsigned FW  = FADE_LOG2 + 1;
  localparam int unsigned PW  = PRESCALE_LOG2 + 1;

  localparam logic [IW-1:0]  LAST_IDX   = IW'(STEPS - 1);
  localparam logic [IW1-1:0] STEPS_W    = IW1'(STEPS);
  localparam logic [DW-1:0]  DWELL_LAST = DW'(STEP_CYCLES - 1);
  localparam logic [FW-1:0]  FADE_LAST  = FW'((1 << FADE_LOG2) - 1);
  localparam logic [PW-1:0]  PRE_LAST   = PW'((1 << PRESCALE_LOG2) - 1);

  // ---------------------------------------------------------------------
  // Palette
  // ---------------------------------------------------------------------
  logic [CW-1:0] palette_q [STEPS];
  logic          addr_ok;
  logic [CW-1:0] target;

  assign addr_ok = ({1'b0, wr_addr} < STEPS_W);

  // Palette write port; out-of-range addresses are dropped.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < STEPS; i++) begin
        palette_q[i] <= '0;
      end
    end else if (wr_en && addr_ok) begin
      palette_q[wr_addr] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------
  // Dwell timer and index
  // ---------------------------------------------------------------------
  logic [DW-1:0] dwell_q, dwell_d;
  logic [IW-1:0] cur_index_q, cur_index_d;
  logic          wrap_q, wrap_d;
  logic          manual;
  logic          expire;
  move_e         move;

  assign manual = step_next | step_prev;
  assign expire = run && (dwell_q == DWELL_LAST);

  // Pick one move per cycle: a manual pulse overrides the timer so there
  // is never a double step; opposing pulses cancel.
  always_comb begin
    move = MOVE_NONE;
    if (step_next && !step_prev) begin
      move = MOVE_FWD;
    end else if (step_prev && !step_next) begin
      move = MOVE_BACK;
    end else if (!manual && expire) begin
      move = MOVE_FWD;
    end
  end

  // Next dwell count, index and wrap flag.
  always_comb begin
    dwell_d     = dwell_q;
    cur_index_d = cur_index_q;
    wrap_d      = 1'b0;
    if (manual) begin
      dwell_d = '0;
    end else if (run) begin
      dwell_d = expire ? '0 : dwell_q + 1'b1;
    end
    case (move)
      MOVE_FWD: begin
        cur_index_d = (cur_index_q == LAST_IDX) ? '0 : cur_index_q + 1'b1;
        wrap_d      = (cur_index_q == LAST_IDX);
      end
      MOVE_BACK: begin
        cur_index_d = (cur_index_q == '0) ? LAST_IDX : cur_index_q - 1'b1;
      end
      default: begin
        cur_index_d = cur_index_q;
      end
    endcase
  end

  // Dwell, index and wrap registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dwell_q     <= '0;
      cur_index_q <= '0;
      wrap_q      <= 1'b0;
    end else begin
      dwell_q     <= dwell_d;
      cur_index_q <= cur_index_d;
      wrap_q      <= wrap_d;
    end
  end

  assign target = palette_q[cur_index_q];

  // ---------------------------------------------------------------------
  // Prescalers and shared PWM counter
  // ---------------------------------------------------------------------
  logic [FW-1:0]   fade_cnt_q;
  logic [PW-1:0]   pre_cnt_q;
  logic [BITS-1:0] pwm_cnt_q;
  logic            fade_tick;
  logic            pwm_tick;
  logic            period_start;

  assign fade_tick    = (fade_cnt_q == FADE_LAST);
  assign pwm_tick     = (pre_cnt_q == PRE_LAST);
  assign period_start = pwm_tick && (pwm_cnt_q == '1);

  // Free-running fade and PWM prescalers; PWM counter wraps naturally.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fade_cnt_q <= '0;
      pre_cnt_q  <= '0;
      pwm_cnt_q  <= '0;
    end else begin
      fade_cnt_q <= fade_tick ? '0 : fade_cnt_q + 1'b1;
      pre_cnt_q  <= pwm_tick ? '0 : pre_cnt_q + 1'b1;
      if (pwm_tick) begin
        pwm_cnt_q <= pwm_cnt_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Displayed colour: hard switch or 1-LSB-per-tick crossfade
  // ---------------------------------------------------------------------
  logic [CW-1:0]   cur_color_q, color_d;
  logic [BITS-1:0] cur_ch, tgt_ch;

  // Each channel walks independently toward its target field.
  always_comb begin
    color_d = cur_color_q;
    cur_ch  = '0;
    tgt_ch  = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      cur_ch = BITS'(chan_slice(MAX_COLOR_W'(cur_color_q), BITS, c));
      tgt_ch = BITS'(chan_slice(MAX_COLOR_W'(target), BITS, c));
      if (!fade_en) begin
        color_d[c*BITS +: BITS] = tgt_ch;
      end else if (fade_tick) begin
        if (cur_ch < tgt_ch) begin
          color_d[c*BITS +: BITS] = cur_ch + 1'b1;
        end else if (cur_ch > tgt_ch) begin
          color_d[c*BITS +: BITS] = cur_ch - 1'b1;
        end
      end
    end
  end

  // Displayed colour register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cur_color_q <= '0;
    end else begin
      cur_color_q <= color_d;
    end
  end

  // ---------------------------------------------------------------------
  // PWM channels
  // ---------------------------------------------------------------------
  for (genvar g = 0; g < CHANNELS; g++) begin : g_pwm
    rgb_pwm_channel #(
      .BITS   (BITS),
      .INVERT (INVERT)
    ) u_ch (
      .clk_i          (CLK),
      .rst_i          (RST),
      .pwm_cnt_i      (pwm_cnt_q),
      .period_start_i (period_start),
      .duty_i         (BITS'(chan_slice(MAX_COLOR_W'(cur_color_q), BITS, g))),
      .pin_o          (PWM_PIN[g])
    );
  end

  assign cur_index = cur_index_q;
  assign cur_color = cur_color_q;
  assign wrap      = wrap_q;

endmodule
